// File: rtl/gsim_host.sv
// Host sequencer for a 16-unknown solver: buffers b, streams it out, collects the 16 results.
// Optional WAIT-phase abort when GSIM_HOST_TIMEOUT_EN is defined.
module gsim_host #(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ld_en,
  input  logic [3:0]  ld_addr,
  input  logic [15:0] ld_data,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        in_en,
  output logic [15:0] b_in,
  input  logic        out_valid,
  input  logic [31:0] x_out,
  input  logic [3:0]  rd_addr,
  output logic [31:0] rd_data
`ifdef GSIM_HOST_TIMEOUT_EN
  ,
  output logic        timeout
`endif
);

  typedef enum logic [1:0] {StIdle, StSend, StWait, StDone} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  idx_q, idx_d;
  logic [15:0] b_q [16];
  logic [31:0] res_q [16];
  logic [31:0] rd_data_q;
  logic        b_we;
  logic        res_we;

`ifdef GSIM_HOST_TIMEOUT_EN
  localparam int unsigned WaitW = $clog2(TIMEOUT_CYCLES + 1);

  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
  logic             timeout_q, timeout_d;

  assign timeout = timeout_q;
`else
  // Parameter only matters for the timeout build.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    b_we    = 1'b0;
    res_we  = 1'b0;
`ifdef GSIM_HOST_TIMEOUT_EN
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
`endif
    case (state_q)
      StIdle: begin
        // Load is applied on the same edge that accepts start, so the new value is sent.
        b_we = ld_en;
        if (start) begin
          state_d = StSend;
          cnt_d   = 4'd0;
`ifdef GSIM_HOST_TIMEOUT_EN
          timeout_d = 1'b0;
`endif
        end
      end
      StSend: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          state_d = StWait;
          idx_d   = 4'd0;
`ifdef GSIM_HOST_TIMEOUT_EN
          wait_cnt_d = '0;
`endif
        end
      end
      StWait: begin
        if (out_valid) begin
          res_we = 1'b1;
          idx_d  = idx_q + 4'd1;
          if (idx_q == 4'd15) state_d = StDone;
        end
`ifdef GSIM_HOST_TIMEOUT_EN
        wait_cnt_d = wait_cnt_q + 1'b1;
        // A final capture landing on the last allowed cycle still counts as success.
        if (!(out_valid && idx_q == 4'd15) && wait_cnt_q == WaitW'(TIMEOUT_CYCLES - 1)) begin
          state_d   = StDone;
          timeout_d = 1'b1;
        end
`endif
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign busy    = (state_q == StSend) || (state_q == StWait);
  assign done    = (state_q == StDone);
  assign in_en   = (state_q == StSend);
  assign b_in    = in_en ? b_q[cnt_q] : 16'd0;
  assign rd_data = rd_data_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      idx_q     <= 4'd0;
      rd_data_q <= 32'd0;
      for (int i = 0; i < 16; i++) begin
        b_q[i]   <= 16'd0;
        res_q[i] <= 32'd0;
      end
`ifdef GSIM_HOST_TIMEOUT_EN
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      rd_data_q <= res_q[rd_addr];
      if (b_we)   b_q[ld_addr] <= ld_data;
      if (res_we) res_q[idx_q] <= x_out;
`ifdef GSIM_HOST_TIMEOUT_EN
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

endmodule

// File: tb/tb_gsim_host.sv
// Randomized bench for gsim_host: per-cycle comparison against a transaction-level model,
// plus directed scenarios with literal expectations.
module tb_gsim_host;

  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ld_en = 1'b0;
  logic [3:0]  ld_addr = '0;
  logic [15:0] ld_data = '0;
  logic        start = 1'b0;
  logic        busy, done, in_en;
  logic [15:0] b_in;
  logic        out_valid = 1'b0;
  logic [31:0] x_out = '0;
  logic [3:0]  rd_addr = '0;
  logic [31:0] rd_data;
`ifdef GSIM_HOST_TIMEOUT_EN
  logic        timeout;
`endif

  gsim_host #(.TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .ld_en     (ld_en),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .in_en     (in_en),
    .b_in      (b_in),
    .out_valid (out_valid),
    .x_out     (x_out),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data)
`ifdef GSIM_HOST_TIMEOUT_EN
    ,
    .timeout   (timeout)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int done_cnt = 0;
  bit chk_en = 1'b0;
  bit rnd_rd = 1'b0;
  logic [15:0] seen [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: a solve is "16 sends pending", then "waiting for N captures".
  logic [15:0] m_b [16];
  logic [31:0] m_res [16];
  logic [31:0] m_rd;
  int          send_left, caps, wcyc;
  bit          waiting, m_done, m_to;

  always @(posedge clk) begin
    bit idle, nd;
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        m_b[i] = '0;
        m_res[i] = '0;
      end
      m_rd = '0; send_left = 0; caps = 0; wcyc = 0;
      waiting = 0; m_done = 0; m_to = 0;
    end else begin
      idle = (send_left == 0) && !waiting && !m_done;
      m_rd = m_res[rd_addr];
      nd = 0;
      if (idle) begin
        if (ld_en) m_b[ld_addr] = ld_data;
        if (start) begin
          send_left = 16;
          m_to = 0;
        end
      end else if (send_left > 0) begin
        send_left--;
        if (send_left == 0) begin
          waiting = 1; caps = 0; wcyc = 0;
        end
      end else if (waiting) begin
        if (out_valid) begin
          m_res[caps] = x_out;
          caps++;
          if (caps == 16) begin
            waiting = 0;
            nd = 1;
          end
        end
`ifdef GSIM_HOST_TIMEOUT_EN
        if (waiting) begin
          wcyc++;
          if (wcyc == TO) begin
            waiting = 0; nd = 1; m_to = 1;
          end
        end
`endif
      end
      m_done = nd;
    end
  end

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (chk_en) begin
      check("busy", busy, send_left > 0 || waiting);
      check("done", done, m_done);
      check("in_en", in_en, send_left > 0);
      check("b_in", b_in, (send_left > 0) ? m_b[16 - send_left] : 16'd0);
      check("rd_data", rd_data, m_rd);
`ifdef GSIM_HOST_TIMEOUT_EN
      check("timeout", timeout, m_to);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_rd) rd_addr = 4'($urandom);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic load(input logic [3:0] a, input logic [15:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_en = 1'b0;
  endtask

  // Call in the first SEND cycle; records the stream, optionally with ignored noise.
  task automatic run_send(input bit noise);
    for (int i = 0; i < 16; i++) begin
      if (noise) begin
        out_valid = 1'($urandom); x_out = $urandom;
        start = 1'($urandom);
        ld_en = ($urandom % 4) == 0; ld_addr = 4'($urandom); ld_data = 16'($urandom);
      end
      @(negedge clk);
      seen[i] = b_in;
      tick();
    end
    out_valid = 0; start = 0; ld_en = 0;
  endtask

  task automatic respond(input int n, input bit fixed, input int maxgap, input int abort_at,
                         output bit aborted);
    aborted = 0;
    for (int i = 0; i < n; i++) begin
      if (i == abort_at) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
        aborted = 1;
        break;
      end
      repeat ($urandom_range(0, maxgap)) begin
        out_valid = 0; x_out = $urandom; start = 1'($urandom);
        tick();
      end
      out_valid = 1; x_out = fixed ? 32'h100 + 32'(i) : $urandom; start = 0;
      tick();
    end
    out_valid = 0; start = 0;
  endtask

  task automatic wait_done(input int max_cyc);
    bit got = 0;
    for (int i = 0; i < max_cyc && !got; i++) begin
      @(negedge clk);
      if (done === 1'b1) got = 1;
      else tick();
    end
    n_chk++;
    if (!got) begin
      n_err++;
      $display("FAIL wait_done: got no done pulse expected one within %0d cycles", max_cyc);
    end
  endtask

  initial begin
    bit ab;
    int dc0;
    do_reset();
    chk_en = 1'b1;

    // Idle out_valid must not land in the result buffer.
    out_valid = 1; x_out = 32'hDEAD;
    tick();
    out_valid = 0;

    for (int i = 0; i < 16; i++) load(4'(i), 16'(i + 1));
    dc0 = done_cnt;
    start = 1;
    tick();
    start = 0;
    for (int i = 0; i < 16; i++) begin
      if (i == 1) begin
        ld_en = 1; ld_addr = 4'd3; ld_data = 16'hFFFF;
      end else ld_en = 0;
      @(negedge clk);
      check("stream_lit", b_in, 32'(i + 1));
      check("in_en_lit", in_en, 1);
      tick();
    end
    ld_en = 0;
    @(negedge clk);
    check("in_en_after_send", in_en, 0);
    respond(16, 1, 3, -1, ab);
    wait_done(8);
    tick(); tick();
    check("done_once", done_cnt - dc0, 1);
    rd_addr = 4'd5;
    tick();
    @(negedge clk);
    check("rd5_lit", rd_data, 32'h105);
    rd_addr = 4'd0;
    tick();
    @(negedge clk);
    check("rd0_not_dead", rd_data, 32'h100);

    // Buffer untouched by the load issued during SEND.
    start = 1;
    tick();
    start = 0;
    run_send(0);
    check("b4_kept", seen[3], 16'd4);
    respond(16, 0, 2, -1, ab);
    wait_done(8);
    tick();

    // Reset in the cnt=7 SEND cycle.
    dc0 = done_cnt;
    start = 1;
    tick();
    start = 0;
    repeat (7) tick();
    @(negedge clk);
    check("cnt7_stream", b_in, 16'd8);
    do_reset();
    @(negedge clk);
    check("rst_in_en", in_en, 0);
    check("rst_busy", busy, 0);
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a);
      tick();
      @(negedge clk);
      check("rst_rd_zero", rd_data, 0);
    end
    check("rst_no_done", done_cnt - dc0, 0);

`ifdef GSIM_HOST_TIMEOUT_EN
    dc0 = done_cnt;
    start = 1;
    tick();
    start = 0;
    run_send(0);
    respond(10, 0, 2, -1, ab);
    wait_done(TO + 8);
    check("timeout_set", timeout, 1);
    tick(); tick();
    check("timeout_done_once", done_cnt - dc0, 1);
    start = 1;
    tick();
    start = 0;
    @(negedge clk);
    check("timeout_cleared", timeout, 0);
    tick();
    run_send(0);
    respond(16, 0, 1, -1, ab);
    wait_done(8);
    tick();
`endif

    rnd_rd = 1;
    for (int it = 0; it < 24; it++) begin
      repeat ($urandom_range(0, 4)) load(4'($urandom), 16'($urandom));
      ld_en = 1'($urandom); ld_addr = 4'($urandom); ld_data = 16'($urandom);
      start = 1;
      tick();
      start = 0; ld_en = 0;
      run_send(1);
      respond(16, 0, 3, ($urandom % 6 == 0) ? int'($urandom_range(0, 15)) : -1, ab);
      if (!ab) wait_done(8);
      repeat ($urandom_range(1, 4)) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish within time limit");
    $fatal(1);
  end

endmodule

// File: doc/gsim_host.md
GSIM_HOST -- requirements
Module: gsim_host

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 4096, meaning the maximum cycles spent in WAIT before abort (used only with GSIM_HOST_TIMEOUT_EN).
REQ-002 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port ld_en, input, 1, the b-buffer write strobe.
REQ-005 SHALL have port ld_addr, input, 4, the b-buffer index (0 = b1).
REQ-006 SHALL have port ld_data, input, 16, the b value, two's complement.
REQ-007 SHALL have port start, input, 1, a one-cycle pulse that begins a solve.
REQ-008 SHALL have port busy, output, 1, high from start accept until done.
REQ-009 SHALL have port done, output, 1, a one-cycle pulse when the solve ends.
REQ-010 SHALL have port in_en, output, 1, the solver input-valid strobe.
REQ-011 SHALL have port b_in, output, 16, the solver b stream.
REQ-012 SHALL have port out_valid, input, 1, the solver result-valid strobe.
REQ-013 SHALL have port x_out, input, 32, the solver result stream.
REQ-014 SHALL have port rd_addr, input, 4, the result-buffer index.
REQ-015 SHALL have port rd_data, output, 32, the result word, registered.
REQ-016 SHALL have port timeout, output, 1, a sticky abort flag (exists only with GSIM_HOST_TIMEOUT_EN).

Function
REQ-017 SHALL implement states IDLE, SEND, WAIT and DONE.
REQ-018 IDLE: start=1 SHALL move the FSM to SEND next cycle and set busy=1; start in any other state SHALL be ignored.
REQ-019 SEND: for 16 consecutive cycles it SHALL drive in_en=1 and b_in=b[cnt], cnt=0..15, b1 first; after cnt=15 it SHALL move to WAIT.
REQ-020 in_en SHALL be 0 and b_in SHALL be 0 outside SEND.
REQ-021 WAIT: each cycle with out_valid=1 SHALL write x_out into res[idx] and increment idx; the capture with idx=15 SHALL move the FSM to DONE.
REQ-022 out_valid in IDLE, SEND or DONE SHALL be ignored; gaps between out_valid pulses SHALL be allowed.
REQ-023 DONE SHALL last one cycle with done=1 and busy=0, then return to IDLE.
REQ-024 A ld_en write SHALL take effect only in IDLE; it SHALL be ignored while busy=1, so b is stable during SEND.
REQ-025 rd_data SHALL equal res[rd_addr] one cycle after rd_addr is presented, in any state.
REQ-026 Latency: start at cycle T SHALL give in_en=1 on cycles T+1..T+16.
REQ-027 ld_en and start asserted in the same IDLE cycle SHALL write first; the new value SHALL be sent.

Reset
REQ-028 On reset=1 at a clock edge the FSM SHALL go to IDLE and cnt, idx, busy, done, in_en, b_in, rd_data and timeout SHALL become 0.
REQ-029 All 16 result entries SHALL be cleared to 0 on reset; b-buffer contents SHALL be cleared to 0.
REQ-030 Reset mid-SEND or mid-WAIT SHALL abort with no done pulse; in_en SHALL be 0 in the cycle after reset.

Configuration
REQ-031 With GSIM_HOST_TIMEOUT_EN defined, a WAIT cycle counter SHALL run, and reaching TIMEOUT_CYCLES without the 16th capture SHALL set timeout=1, pulse done and return to IDLE; timeout SHALL clear on the next accepted start or on reset.
REQ-032 Without GSIM_HOST_TIMEOUT_EN, the timeout port and counter SHALL be absent, and WAIT SHALL last indefinitely until 16 captures.

Verification
REQ-033 Load b[i]=i+1, pulse start -> in_en high on cycles T+1..T+16 with b_in=1,2,...,16, then low.
REQ-034 Respond with 16 out_valid pulses x_out=32'h100+i, spaced randomly -> done pulses once, and rd_addr=5 gives rd_data=32'h105 on the next cycle.
REQ-035 ld_en addr 3 data 16'hFFFF during SEND -> the stream still carries the old b4; the buffer is unchanged afterwards.
REQ-036 Assert reset at SEND cnt=7 -> in_en=0 next cycle, busy=0, no done, all rd_data=0.
REQ-037 With GSIM_HOST_TIMEOUT_EN and TIMEOUT_CYCLES=64, send only 10 out_valid -> timeout=1 and one done pulse; the following start clears timeout.
REQ-038 out_valid=1 with x_out=32'hDEAD in IDLE, then a full solve -> res[0] holds the first WAIT capture, not 32'hDEAD.
